br_ram_flops_counter_table: RTL and testbench

Flop-based table of `Depth` counters, each `Width` bits wide, with `NumIncPorts` independent increment ports, one clear port and one read port. Same-address updates are merged internally through a two-stage read-modify-write pipeline with forwarding. The block is the next generation of the flop RAM family: channel count, arithmetic mode and read latency are parametrised, and it adds atomic accumulate semantics that a plain flop RAM lacks. It sits beside datapath blocks that keep per-ID statistics or credits.

---
 rtl/br_ram_flops_counter_table_if.sv | 38 +++
 rtl/br_ram_flops_counter_table.sv | 144 ++++++++++++++
 tb/tb_br_ram_flops_counter_table.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/br_ram_flops_counter_table_if.sv
// rtl/br_ram_flops_counter_table_if.sv - increment/clear/read bundle for the counter table
// Optional overflow status signals exist only with BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN.
interface br_ram_flops_counter_table_if #(
    parameter int Width        = 8,
    parameter int NumIncPorts  = 2,
    parameter int IncWidth     = 4,
    parameter int AddressWidth = 4
) ();
    logic [NumIncPorts-1:0]                   inc_valid;
    logic [NumIncPorts-1:0][AddressWidth-1:0] inc_addr;
    logic [NumIncPorts-1:0][IncWidth-1:0]     inc_amount;
    logic                                     clr_valid;
    logic [AddressWidth-1:0]                  clr_addr;
    logic                                     rd_addr_valid;
    logic [AddressWidth-1:0]                  rd_addr;
    logic                                     rd_data_valid;
    logic [Width-1:0]                         rd_data;
`ifdef BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN
    logic                                     overflow;
    logic [AddressWidth-1:0]                  overflow_addr;
`endif

    modport master (
        output inc_valid, inc_addr, inc_amount, clr_valid, clr_addr, rd_addr_valid, rd_addr,
`ifdef BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN
        input  overflow, overflow_addr,
`endif
        input  rd_data_valid, rd_data
    );

    modport slave (
        input  inc_valid, inc_addr, inc_amount, clr_valid, clr_addr, rd_addr_valid, rd_addr,
`ifdef BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN
        output overflow, overflow_addr,
`endif
        output rd_data_valid, rd_data
    );
endinterface

// File: rtl/br_ram_flops_counter_table.sv
// rtl/br_ram_flops_counter_table.sv - flop table of counters with merged multi-port increments
// Optional sticky overflow status is enabled by BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN.
module br_ram_flops_counter_table #(
    parameter int Depth       = 16,
    parameter int Width       = 8,
    parameter int NumIncPorts = 2,
    parameter int IncWidth    = 4,
    parameter int Saturate    = 0,
    parameter int RdLatency   = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    br_ram_flops_counter_table_if.slave        tbl
);
    localparam int AddressWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int SumWidth     = Width + $clog2(NumIncPorts) + 1;
    localparam logic [AddressWidth:0] DepthW  = (AddressWidth + 1)'(Depth);
    localparam logic [SumWidth-1:0]   MaxSum  = {{(SumWidth - Width){1'b0}}, {Width{1'b1}}};

    function automatic logic addr_ok(input logic [AddressWidth-1:0] a);
        return {1'b0, a} < DepthW;
    endfunction

    logic [NumIncPorts-1:0]                   inc_v_q, inc_v_d;
    logic [NumIncPorts-1:0][AddressWidth-1:0] inc_addr_q, inc_addr_d;
    logic [NumIncPorts-1:0][IncWidth-1:0]     inc_amt_q, inc_amt_d;
    logic                                     clr_v_q, clr_v_d;
    logic [AddressWidth-1:0]                  clr_addr_q, clr_addr_d;
    logic [Width-1:0]                         cnt_q [Depth];
    logic [Width-1:0]                         cnt_d [Depth];
    logic [SumWidth-1:0]                      sum   [Depth];
    logic [Depth-1:0]                         hit, ovf_vec;
    logic [RdLatency-1:0]                     rd_v_q, rd_v_d;
    logic [Width-1:0]                         rd_dat_q [RdLatency];
    logic [Width-1:0]                         rd_dat_d [RdLatency];

    always_comb begin
        for (int p = 0; p < NumIncPorts; p++) begin
            inc_v_d[p] = tbl.inc_valid[p] && addr_ok(tbl.inc_addr[p]);
        end
        inc_addr_d = tbl.inc_addr;
        inc_amt_d  = tbl.inc_amount;
        clr_v_d    = tbl.clr_valid && addr_ok(tbl.clr_addr);
        clr_addr_d = tbl.clr_addr;
    end

    // Stage B: the array plus the merged stage-A requests; also the forwarded view for reads.
    always_comb begin
        for (int e = 0; e < Depth; e++) begin
            hit[e] = clr_v_q && (clr_addr_q == AddressWidth'(e));
            sum[e] = hit[e] ? '0 : SumWidth'(cnt_q[e]);
            for (int p = 0; p < NumIncPorts; p++) begin
                if (inc_v_q[p] && (inc_addr_q[p] == AddressWidth'(e))) begin
                    hit[e] = 1'b1;
                    sum[e] = sum[e] + SumWidth'(inc_amt_q[p]);
                end
            end
            ovf_vec[e] = hit[e] && (sum[e] > MaxSum);
            if (!hit[e]) begin
                cnt_d[e] = cnt_q[e];
            end else if ((Saturate != 0) && ovf_vec[e]) begin
                cnt_d[e] = {Width{1'b1}};
            end else begin
                cnt_d[e] = sum[e][Width-1:0];
            end
        end
    end

    // Reads sample the forwarded value, so they see everything accepted before this cycle.
    always_comb begin
        rd_v_d[0]   = tbl.rd_addr_valid && addr_ok(tbl.rd_addr);
        rd_dat_d[0] = rd_v_d[0] ? cnt_d[tbl.rd_addr] : rd_dat_q[0];
        for (int i = 1; i < RdLatency; i++) begin
            rd_v_d[i]   = rd_v_q[i-1];
            rd_dat_d[i] = rd_v_q[i-1] ? rd_dat_q[i-1] : rd_dat_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_v_q    <= '0;
            inc_addr_q <= '0;
            inc_amt_q  <= '0;
            clr_v_q    <= 1'b0;
            clr_addr_q <= '0;
            rd_v_q     <= '0;
            for (int e = 0; e < Depth; e++) cnt_q[e] <= '0;
            for (int i = 0; i < RdLatency; i++) rd_dat_q[i] <= '0;
        end else begin
            inc_v_q    <= inc_v_d;
            inc_addr_q <= inc_addr_d;
            inc_amt_q  <= inc_amt_d;
            clr_v_q    <= clr_v_d;
            clr_addr_q <= clr_addr_d;
            rd_v_q     <= rd_v_d;
            cnt_q      <= cnt_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    assign tbl.rd_data_valid = rd_v_q[RdLatency-1];
    assign tbl.rd_data       = rd_dat_q[RdLatency-1];

`ifdef BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN
    logic                    ovf_q, ovf_d;
    logic [AddressWidth-1:0] ovf_addr_q, ovf_addr_d;

    // Descending scan so the lowest overflowing index wins.
    always_comb begin
        ovf_d      = ovf_q;
        ovf_addr_d = ovf_addr_q;
        if (!ovf_q) begin
            for (int e = Depth - 1; e >= 0; e--) begin
                if (ovf_vec[e]) begin
                    ovf_d      = 1'b1;
                    ovf_addr_d = AddressWidth'(e);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q      <= 1'b0;
            ovf_addr_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            ovf_addr_q <= ovf_addr_d;
        end
    end

    assign tbl.overflow      = ovf_q;
    assign tbl.overflow_addr = ovf_addr_q;
`endif

    for (genvar p = 0; p < NumIncPorts; p++) begin : g_inc_chk
        a_inc_addr: assert property (@(posedge clk) disable iff (!rst_n)
            tbl.inc_valid[p] |-> addr_ok(tbl.inc_addr[p]));
    end
    a_clr_addr: assert property (@(posedge clk) disable iff (!rst_n)
        tbl.clr_valid |-> addr_ok(tbl.clr_addr));
    a_rd_addr: assert property (@(posedge clk) disable iff (!rst_n)
        tbl.rd_addr_valid |-> addr_ok(tbl.rd_addr));
endmodule

// File: tb/tb_br_ram_flops_counter_table.sv
// tb/tb_br_ram_flops_counter_table.sv - self-checking bench: wrap/latency-1 and saturate/latency-3 tables
// Overflow checks are compiled in with BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN.
module tb_br_ram_flops_counter_table;
    localparam int NONE = 1 << 30;

    typedef struct {
        logic [1:0] inc_v;
        logic [3:0] a0, m0, a1, m1;
        logic       clr_v;
        logic [3:0] clr_a;
        logic       rd_v;
        logic [3:0] rd_a;
        int         exp0, exp1;
    } vec_t;

    typedef struct {
        int due;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    br_ram_flops_counter_table_if #(.Width(8), .NumIncPorts(2), .IncWidth(4), .AddressWidth(4)) bus0 ();
    br_ram_flops_counter_table_if #(.Width(8), .NumIncPorts(2), .IncWidth(4), .AddressWidth(4)) bus1 ();

    br_ram_flops_counter_table #(.Depth(16), .Width(8), .NumIncPorts(2), .IncWidth(4),
                                 .Saturate(0), .RdLatency(1))
        dut0 (.clk(clk), .rst_n(rst_n), .tbl(bus0));
    br_ram_flops_counter_table #(.Depth(16), .Width(8), .NumIncPorts(2), .IncWidth(4),
                                 .Saturate(1), .RdLatency(3))
        dut1 (.clk(clk), .rst_n(rst_n), .tbl(bus1));

    int   m0 [16];
    int   m1 [16];
    exp_t q0[$], q1[$], dq0[$], dq1[$];
    int   cyc, last0, last1, resp1;
    int   ovf0_due, ovf0_addr, ovf1_due, ovf1_addr;
    int   checks, passed;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] iv, input int a0, input int am0,
                                input int a1, input int am1, input logic cv, input int ca,
                                input logic rv, input int ra, input int e0, input int e1);
        vec_t v;
        v.inc_v = iv;
        v.a0 = 4'(a0); v.m0 = 4'(am0); v.a1 = 4'(a1); v.m1 = 4'(am1);
        v.clr_v = cv; v.clr_a = 4'(ca); v.rd_v = rv; v.rd_a = 4'(ra);
        v.exp0 = e0; v.exp1 = e1;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
    endtask

    task automatic drive(input vec_t v);
        bus0.inc_valid = v.inc_v;  bus1.inc_valid = v.inc_v;
        bus0.inc_addr = {v.a1, v.a0};  bus1.inc_addr = {v.a1, v.a0};
        bus0.inc_amount = {v.m1, v.m0};  bus1.inc_amount = {v.m1, v.m0};
        bus0.clr_valid = v.clr_v;  bus1.clr_valid = v.clr_v;
        bus0.clr_addr = v.clr_a;  bus1.clr_addr = v.clr_a;
        bus0.rd_addr_valid = v.rd_v;  bus1.rd_addr_valid = v.rd_v;
        bus0.rd_addr = v.rd_a;  bus1.rd_addr = v.rd_a;
    endtask

    // Reference: clear zeroes the base, all increments for the entry are summed, then wrap or clamp.
    task automatic model_apply(input vec_t v);
        bit hit;
        int s0, s1;
        for (int e = 0; e < 16; e++) begin
            hit = v.clr_v && (int'(v.clr_a) == e);
            s0  = hit ? 0 : m0[e];
            s1  = hit ? 0 : m1[e];
            if (v.inc_v[0] && int'(v.a0) == e) begin hit = 1; s0 += int'(v.m0); s1 += int'(v.m0); end
            if (v.inc_v[1] && int'(v.a1) == e) begin hit = 1; s0 += int'(v.m1); s1 += int'(v.m1); end
            if (hit) begin
                if (s0 > 255 && ovf0_due == NONE) begin ovf0_due = cyc + 2; ovf0_addr = e; end
                if (s1 > 255 && ovf1_due == NONE) begin ovf1_due = cyc + 2; ovf1_addr = e; end
                m0[e] = s0 % 256;
                m1[e] = (s1 > 255) ? 255 : s1;
            end
        end
    endtask

    task automatic check_outputs();
        bit due;
        due = (q0.size() > 0) && (q0[0].due == cyc);
        chk("rd_valid0", int'(bus0.rd_data_valid), int'(due));
        if (due) begin last0 = q0[0].val; void'(q0.pop_front()); end
        chk("rd_data0", int'(bus0.rd_data), last0);
        due = (q1.size() > 0) && (q1[0].due == cyc);
        chk("rd_valid1", int'(bus1.rd_data_valid), int'(due));
        if (due) begin last1 = q1[0].val; void'(q1.pop_front()); end
        chk("rd_data1", int'(bus1.rd_data), last1);
        if (bus1.rd_data_valid) resp1++;
        if (dq0.size() > 0 && dq0[0].due == cyc) begin
            chk("tbl_rd0", int'(bus0.rd_data), dq0[0].val); void'(dq0.pop_front());
        end
        if (dq1.size() > 0 && dq1[0].due == cyc) begin
            chk("tbl_rd1", int'(bus1.rd_data), dq1[0].val); void'(dq1.pop_front());
        end
`ifdef BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN
        chk("overflow0", int'(bus0.overflow), int'(ovf0_due <= cyc));
        chk("overflow1", int'(bus1.overflow), int'(ovf1_due <= cyc));
        if (ovf0_due <= cyc) chk("overflow_addr0", int'(bus0.overflow_addr), ovf0_addr);
        if (ovf1_due <= cyc) chk("overflow_addr1", int'(bus1.overflow_addr), ovf1_addr);
`endif
    endtask

    task automatic step(input vec_t v);
        drive(v);
        if (v.rd_v) begin
            q0.push_back('{cyc + 1, m0[v.rd_a]});
            q1.push_back('{cyc + 3, m1[v.rd_a]});
            if (v.exp0 >= 0) dq0.push_back('{cyc + 1, v.exp0});
            if (v.exp1 >= 0) dq1.push_back('{cyc + 3, v.exp1});
        end
        model_apply(v);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid0"}, int'(bus0.rd_data_valid), 0);
        chk({tag, "_data0"}, int'(bus0.rd_data), 0);
        chk({tag, "_valid1"}, int'(bus1.rd_data_valid), 0);
        chk({tag, "_data1"}, int'(bus1.rd_data), 0);
`ifdef BR_RAM_FLOPS_COUNTER_TABLE_OVERFLOW_STATUS_EN
        chk({tag, "_ovf0"}, int'(bus0.overflow), 0);
        chk({tag, "_ovf1"}, int'(bus1.overflow), 0);
        chk({tag, "_ovf_addr0"}, int'(bus0.overflow_addr), 0);
`endif
    endtask

    task automatic model_reset();
        for (int e = 0; e < 16; e++) begin m0[e] = 0; m1[e] = 0; end
        q0.delete(); q1.delete(); dq0.delete(); dq1.delete();
        last0 = 0; last1 = 0;
        ovf0_due = NONE; ovf1_due = NONE; ovf0_addr = 0; ovf1_addr = 0;
    endtask

    vec_t idle;

    initial begin
        checks = 0; passed = 0; cyc = 0; resp1 = 0;
        idle = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1);
        model_reset();

        // Directed vectors: {inputs, expected wrap-table read, expected saturate-table read}.
        tbl.push_back(mk(2'b01, 3, 5, 0, 0, 0, 0, 0, 0, -1, -1));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 3, 5, 5));
        tbl.push_back(mk(2'b11, 7, 4, 7, 9, 0, 0, 0, 0, -1, -1));
        tbl.push_back(mk(2'b01, 7, 2, 0, 0, 0, 0, 1, 7, 13, 13));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 7, 15, 15));
        tbl.push_back(mk(2'b01, 9, 10, 0, 0, 0, 0, 0, 0, -1, -1));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 9, 4, 255));
        tbl.push_back(mk(2'b01, 2, 6, 0, 0, 1, 2, 1, 2, 100, 100));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2, 6, 6));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 3, 1, 3, 5, 5));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(2'b10, 0, 0, 8, 3, 1, 7, 0, 0, -1, -1));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 8, 3, 3));

        drive(idle);
        @(posedge clk); @(posedge clk); #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Preload entry 9 to 250 and entry 2 to 100 with both ports.
        for (int i = 0; i < 8; i++) step(mk(2'b11, 9, 15, 9, 15, 0, 0, 0, 0, -1, -1));
        step(mk(2'b01, 9, 10, 0, 0, 0, 0, 0, 0, -1, -1));
        for (int i = 0; i < 3; i++) step(mk(2'b11, 2, 15, 2, 15, 0, 0, 0, 0, -1, -1));
        step(mk(2'b01, 2, 10, 0, 0, 0, 0, 0, 0, -1, -1));

        foreach (tbl[i]) step(tbl[i]);
        for (int i = 0; i < 3; i++) step(idle);
        chk("tbl_drained0", dq0.size(), 0);
        chk("tbl_drained1", dq1.size(), 0);

        for (int i = 0; i < 300; i++) begin
            step(mk(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15), -1, -1));
        end
        for (int i = 0; i < 3; i++) step(idle);

        // Back-to-back sweep: 16 in-order responses on the latency-3 table.
        resp1 = 0;
        for (int a = 0; a < 16; a++) step(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, a, -1, -1));
        for (int i = 0; i < 3; i++) step(idle);
        chk("lat3_responses", resp1, 16);

        // Reset mid-stream with an increment in stage A and a read in flight.
        step(mk(2'b11, 4, 7, 5, 3, 0, 0, 1, 4, -1, -1));
        drive(idle);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        for (int a = 0; a < 16; a++) step(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, a, 0, 0));
        for (int i = 0; i < 3; i++) step(idle);
        chk("post_reset_drained", dq1.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
